lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit between the single-cycle core's data-bus side and a 32-bit-wide synchronous data SRAM.
- Decodes RV64 load/store size from funct3 and performs byte-lane steering, byte enables, and sign/zero extension.
- Splits doubleword accesses into two 32-bit beats and flags misaligned or out-of-range accesses.
- Core stalls (clock-gated) while req_ready is low.

Parameters:
- ADDR_W, 10, SRAM word-address width (2^ADDR_W 32-bit words = 4 KiB).
- XLEN, 64, core data/address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit idle, can accept request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV funct3 size/sign code.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data (LSB-aligned).
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  XLEN  extended load data; 0 for stores/errors.
- resp_err  output  1  access fault, valid with resp_valid.
- mem_en  output  1  SRAM access strobe.
- mem_we  output  1  SRAM write.
- mem_be  output  4  SRAM byte enables.
- mem_addr  output  ADDR_W  SRAM word address.
- mem_wdata  output  32  SRAM write data.
- mem_rdata  input  32  SRAM read data, valid the cycle after mem_en && !mem_we.

Behaviour:
- FSM states: IDLE, ACC0, ACC1, CAP, RESP.
- req_ready = (state == IDLE) && !rst.
- Accept on req_valid && req_ready. All req_* are latched at accept; later changes are ignored.
- Legal loads: funct3 0 lb, 1 lh, 2 lw, 3 ld, 4 lbu, 5 lhu, 6 lwu.
- Legal stores: funct3 0 sb, 1 sh, 2 sw, 3 sd.
- Anything else is an error, e.g. load funct3 7 or store funct3 4..7.
- Alignment: h requires addr[0]==0; w requires addr[1:0]==0; d requires addr[2:0]==0.
- Range: addr[XLEN-1:ADDR_W+2] must be 0.
- Any violation → error path. No mem strobe is issued.
- Error path: IDLE → RESP (resp_valid at accept+1), with resp_err=1 and resp_rdata=0.
- Word index w = addr[ADDR_W+1:2]. A doubleword uses w (low) then w+1 (high). An aligned d never wraps.
- Load b/h/w path: IDLE → ACC0 (mem_en=1, addr w) → CAP (capture mem_rdata) → RESP. resp_valid at accept+3.
- ld path: ACC0 (w) → ACC1 (w+1, capture low) → CAP (capture high) → RESP. resp_valid at accept+4.
- Store sb/sh/sw path: ACC0 (mem_en=1, mem_we=1) → RESP. resp_valid at accept+2.
- sd path: ACC0 (low word, w) → ACC1 (high word, w+1) → RESP. resp_valid at accept+3.
- Load extraction: lane = word >> (8*addr[1:0]). lb/lh/lw sign-extend to 64; lbu/lhu/lwu zero-extend; ld = {high, low}.
- Store byte enables: sb → 4'b0001<<addr[1:0]; sh → 4'b0011<<addr[1:0]; sw and sd beats → 4'hF.
- Store write data: sb → {4{wdata[7:0]}}; sh → {2{wdata[15:0]}}; sw → wdata[31:0]; sd → wdata[31:0] then wdata[63:32].
- Outside ACC0/ACC1: mem_en, mem_we, mem_be, mem_addr, mem_wdata are all 0.
- mem_* are driven only from the state and latched registers, never combinationally from req_*.
- resp_valid is high for exactly one cycle (RESP); there is no backpressure. RESP → IDLE, so req_ready rises at RESP+1.
- resp_rdata and resp_err hold their value until the next RESP.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_err 0; all mem_* 0; req_ready 0 while rst is high, 1 after release.
- Reset mid-operation: abort immediately. No further strobes and no response.
- An sd aborted after ACC0 leaves the low word written; this is acceptable.

Test Plan:
- SRAM word 0 = 0x80FF_7F01. lb addr 0x3 → resp_rdata 0xFFFF_FFFF_FFFF_FF80, resp_valid at accept+3. lbu addr 0x3 → 0x80.
- Store sh wdata 0xBEEF addr 0x6 → mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_addr=1, resp_valid at accept+2. Then lhu 0x6 → 0xBEEF.
- Store sd 0x1122_3344_5566_7788 addr 0x10 → two beats: addr 4 with 0x5566_7788, then addr 5 with 0x1122_3344. Then ld 0x10 → same value, resp_valid at accept+4.
- lw addr 0x2 (misaligned) and sb addr 0x1000 (out of range, ADDR_W=10) → resp_err=1, resp_rdata=0, resp_valid at accept+1, mem_en never asserted.
- Assert rst during ACC1 of ld → no resp_valid. req_ready=1 the cycle after release. Following sw completes normally.
- Back-to-back: req_valid held high with sw then lw to the same address → second accept at RESP+1. lw returns the stored value with sign extension.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Core-side request/response and SRAM-side bus of the load/store unit.
// The master drives requests and returns SRAM read data; the slave is the LSU.
interface lsu_mem_if #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV64 load/store unit in front of a 32-bit synchronous SRAM: size decode, lane
// steering, extension, doubleword split into two beats, and fault detection.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 64
) (
  input logic      clk,
  input logic      rst,
  lsu_mem_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC0 = 3'd1,
    S_ACC1 = 3'd2,
    S_CAP  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_widx;
  logic [31:0]       r_whi;
  logic [31:0]       r_lo;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [XLEN-1:0]   r_resp_rdata;

  logic              w_accept;
  logic              w_illegal;
  logic              w_misal;
  logic              w_oor;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;

  // Shift the addressed lane down and extend according to the load size/sign code.
  function automatic logic [XLEN-1:0] f_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      3'd0:    f_extract = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'd1:    f_extract = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'd2:    f_extract = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'd4:    f_extract = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'd5:    f_extract = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'd6:    f_extract = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: f_extract = {XLEN{1'b0}};
    endcase
  endfunction

  assign bus.req_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept       = bus.req_valid && (r_state == S_IDLE);
  assign w_illegal      = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'd7);
  assign w_oor          = |bus.req_addr[XLEN-1:ADDR_W+2];
  assign w_err          = w_illegal || w_misal || w_oor;

  // Request decode: alignment check plus first-beat store lane steering.
  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'h0;
    w_wdata = 32'h0;
    case (bus.req_funct3[1:0])
      2'd0: begin
        w_be    = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'd1: begin
        w_misal = bus.req_addr[0];
        w_be    = 4'b0011 << bus.req_addr[1:0];
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      2'd2: begin
        w_misal = |bus.req_addr[1:0];
        w_be    = 4'hF;
        w_wdata = bus.req_wdata[31:0];
      end
      default: begin
        w_misal = |bus.req_addr[2:0];
        w_be    = 4'hF;
        w_wdata = bus.req_wdata[31:0];
      end
    endcase
  end

  // Sequencer: latches the request, issues SRAM beats and produces the response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'd0;
      r_off        <= 2'd0;
      r_widx       <= {ADDR_W{1'b0}};
      r_whi        <= 32'h0;
      r_lo         <= 32'h0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= {XLEN{1'b0}};
    end else begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= 32'h0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= bus.req_we;
            r_f3   <= bus.req_funct3;
            r_off  <= bus.req_addr[1:0];
            r_widx <= bus.req_addr[ADDR_W+1:2];
            r_whi  <= bus.req_wdata[63:32];
            if (w_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= {XLEN{1'b0}};
            end else begin
              r_state    <= S_ACC0;
              r_mem_en   <= 1'b1;
              r_mem_we   <= bus.req_we;
              r_mem_addr <= bus.req_addr[ADDR_W+1:2];
              r_mem_be   <= bus.req_we ? w_be : 4'h0;
              r_mem_wdata <= bus.req_we ? w_wdata : 32'h0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACC0: begin
          if (r_f3[1:0] == 2'd3) begin
            r_state     <= S_ACC1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= r_we;
            r_mem_addr  <= r_widx + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_mem_be    <= r_we ? 4'hF : 4'h0;
            r_mem_wdata <= r_we ? r_whi : 32'h0;
          end else if (r_we) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= {XLEN{1'b0}};
          end else begin
            r_state <= S_CAP;
          end
        end
        S_ACC1: begin
          if (r_we) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= {XLEN{1'b0}};
          end else begin
            r_lo    <= bus.mem_rdata;
            r_state <= S_CAP;
          end
        end
        S_CAP: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= (r_f3 == 3'd3) ? {bus.mem_rdata, r_lo}
                                         : f_extract(bus.mem_rdata, r_off, r_f3);
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected responses and
// SRAM write beats; a negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  int   mem_en_cnt;

  lsu_mem_if #(.ADDR_W(10), .XLEN(64)) bus ();

  lsu_mem_ctrl #(.ADDR_W(10), .XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  resp_t       resp_q[$];
  beat_t       beat_q[$];
  logic [31:0] sram [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural synchronous SRAM with byte enables.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= sram[bus.mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares responses and write beats against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_en) mem_en_cnt++;
      if (bus.resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", {63'd0, bus.resp_err}, {63'd0, e.err});
          chk("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      if (bus.mem_en && bus.mem_we) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_addr", {54'd0, bus.mem_addr}, {54'd0, b.addr});
          chk("beat_be", {60'd0, bus.mem_be}, {60'd0, b.be});
          chk("beat_wdata", {32'd0, bus.mem_wdata}, {32'd0, b.wdata});
        end
      end
    end
  end

  // Waits (bounded) for idle, drives one request, pushes its expectation, returns after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] er, input logic ee,
                       input int lat, input logic push, input logic hold, output int acc);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 64'd0, 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    acc = cyc;
    if (push) resp_q.push_back('{rdata: er, err: ee, lat: lat, acc: cyc});
    @(negedge clk);
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.req_wdata = 64'h0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((resp_q.size() != 0 || beat_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  int a0;
  int a1;
  int en_before;

  initial begin
    tests = 0; fails = 0; mem_en_cnt = 0;
    sram[0] = 32'h80FF_7F01;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 64'h0; bus.req_wdata = 64'h0; bus.mem_rdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_mem_en", {63'd0, bus.mem_en}, 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);

    // Loads from the preloaded word: sign and zero extension on every lane size.
    issue(1'b0, 3'd0, 64'h3, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd4, 64'h3, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 3, 1'b1, 1'b0, a0);
    drain();
    repeat (3) @(negedge clk);
    chk("rdata_hold", bus.resp_rdata, 64'h80);
    issue(1'b0, 3'd0, 64'h1, 64'h0, 64'h0000_0000_0000_007F, 1'b0, 3, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd1, 64'h2, 64'h0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 3, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd2, 64'h0, 64'h0, 64'hFFFF_FFFF_80FF_7F01, 1'b0, 3, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd6, 64'h0, 64'h0, 64'h0000_0000_80FF_7F01, 1'b0, 3, 1'b1, 1'b0, a0);

    // sh to the upper half of word 1, then read it back unsigned.
    beat_q.push_back('{addr: 10'd1, be: 4'b1100, wdata: 32'hBEEF_BEEF});
    issue(1'b1, 3'd1, 64'h6, 64'hBEEF, 64'h0, 1'b0, 2, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd5, 64'h6, 64'h0, 64'h0000_0000_0000_BEEF, 1'b0, 3, 1'b1, 1'b0, a0);

    // sd split into two beats, then ld.
    beat_q.push_back('{addr: 10'd4, be: 4'hF, wdata: 32'h5566_7788});
    beat_q.push_back('{addr: 10'd5, be: 4'hF, wdata: 32'h1122_3344});
    issue(1'b1, 3'd3, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 3, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd3, 64'h10, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 4, 1'b1, 1'b0, a0);
    drain();

    // Faults: misaligned, out of range, illegal size codes; none may strobe the SRAM.
    en_before = mem_en_cnt;
    issue(1'b0, 3'd2, 64'h2, 64'h0, 64'h0, 1'b1, 1, 1'b1, 1'b0, a0);
    issue(1'b1, 3'd0, 64'h1000, 64'hAB, 64'h0, 1'b1, 1, 1'b1, 1'b0, a0);
    issue(1'b0, 3'd7, 64'h0, 64'h0, 64'h0, 1'b1, 1, 1'b1, 1'b0, a0);
    issue(1'b1, 3'd4, 64'h0, 64'h0, 64'h0, 1'b1, 1, 1'b1, 1'b0, a0);
    drain();
    chk("err_no_strobe", 64'(mem_en_cnt - en_before), 64'd0);

    // Reset during the second beat of an ld: no response, ready right after release.
    issue(1'b0, 3'd3, 64'h10, 64'h0, 64'h0, 1'b0, 4, 1'b0, 1'b0, a0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_in_rst", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    chk("mem_en_in_rst", {63'd0, bus.mem_en}, 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_abort", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);

    beat_q.push_back('{addr: 10'd8, be: 4'hF, wdata: 32'hCAFE_BABE});
    issue(1'b1, 3'd2, 64'h20, 64'h0000_0001_CAFE_BABE, 64'h0, 1'b0, 2, 1'b1, 1'b0, a0);
    drain();

    // Back-to-back with req_valid held: second accept lands one cycle after RESP.
    beat_q.push_back('{addr: 10'd9, be: 4'hF, wdata: 32'h8765_4321});
    issue(1'b1, 3'd2, 64'h24, 64'hDEAD_0000_8765_4321, 64'h0, 1'b0, 2, 1'b1, 1'b1, a0);
    issue(1'b0, 3'd2, 64'h24, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 3, 1'b1, 1'b0, a1);
    chk("b2b_accept_gap", 64'(a1 - a0), 64'd3);
    drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
